led_flash_ctrl: RTL and testbench

Multi-channel LED flash controller for the thermometer's status LEDs. It generalises the single-group fixed-duration flasher. Each channel is armed independently by a rising edge on its trigger and holds its LED either solid or blinking for a programmed number of milliseconds. Optional retrigger and abort are supported, and a one-cycle completion pulse is produced. It sits between the control FSMs (measurement/transmit done flags) and the board LED pins.

---
 rtl/led_flash_ctrl.sv | 146 ++++++++++++++
 tb/tb_led_flash_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_flash_ctrl.sv
// rtl/led_flash_ctrl.sv - multi-channel LED flash controller
// Per-channel solid/blink activation timed in milliseconds from a shared 1 kHz tick.
module led_flash_ctrl #(
  parameter int N_CH      = 4,
  parameter int SYS_FREQ  = 100_000_000,
  parameter int PERIOD_MS = 20000,
  parameter int BLINK_MS  = 250,
  parameter bit RETRIGGER = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] trigger,
  input  logic [N_CH-1:0] blink_en,
  input  logic [N_CH-1:0] abort,
  output logic [N_CH-1:0] led_on,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] done
);

  localparam int TICK_DIV = SYS_FREQ / 1000;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int MSW      = $clog2(PERIOD_MS + 1);
  localparam int BKW      = $clog2(BLINK_MS + 1);

  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [MSW-1:0] MS_LAST  = MSW'(PERIOD_MS - 1);
  localparam logic [BKW-1:0] BLK_LAST = BKW'(BLINK_MS - 1);

  if ((SYS_FREQ % 1000) != 0 || SYS_FREQ < 2000) begin : g_bad_freq
    $error("led_flash_ctrl: SYS_FREQ must be a multiple of 1000 and >= 2000");
  end
  if (PERIOD_MS < 1 || BLINK_MS < 1) begin : g_bad_ms
    $error("led_flash_ctrl: PERIOD_MS and BLINK_MS must be >= 1");
  end
  if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
    $error("led_flash_ctrl: N_CH must be 1..32");
  end

  typedef enum logic {S_IDLE, S_ACTIVE} ch_state_e;

  logic [PW-1:0]   pre_cnt;
  logic            tick;
  logic [N_CH-1:0] trig_q;
  logic [N_CH-1:0] rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q <= '0;
    end else begin
      trig_q <= trigger;
    end
  end

  assign rise = trigger & ~trig_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_e      state_q, state_d;
    logic [MSW-1:0] ms_q, ms_d;
    logic [BKW-1:0] blk_q, blk_d;
    logic           phase_q, phase_d;
    logic           mode_q, mode_d;
    logic           done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= S_IDLE;
        ms_q    <= '0;
        blk_q   <= '0;
        phase_q <= 1'b0;
        mode_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        ms_q    <= ms_d;
        blk_q   <= blk_d;
        phase_q <= phase_d;
        mode_q  <= mode_d;
        done_q  <= done_d;
      end
    end

    always_comb begin
      state_d = state_q;
      ms_d    = ms_q;
      blk_d   = blk_q;
      phase_d = phase_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          // abort beats a coincident rise, so an aborted start never lights the LED
          if (rise[i] && !abort[i]) begin
            state_d = S_ACTIVE;
            ms_d    = '0;
            blk_d   = '0;
            phase_d = 1'b1;
            mode_d  = blink_en[i];
          end
        end
        S_ACTIVE: begin
          if (abort[i]) begin
            state_d = S_IDLE;
          end else if (RETRIGGER && rise[i]) begin
            ms_d    = '0;
            blk_d   = '0;
            phase_d = 1'b1;
            mode_d  = blink_en[i];
          end else if (tick) begin
            if (ms_q == MS_LAST) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              ms_d = ms_q + MSW'(1);
              if (mode_q) begin
                if (blk_q == BLK_LAST) begin
                  blk_d   = '0;
                  phase_d = ~phase_q;
                end else begin
                  blk_d = blk_q + BKW'(1);
                end
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    assign busy[i]   = (state_q == S_ACTIVE);
    assign led_on[i] = (state_q == S_ACTIVE) && (mode_q ? phase_q : 1'b1);
    assign done[i]   = done_q;
  end

endmodule

// File: tb/tb_led_flash_ctrl.sv
// tb/tb_led_flash_ctrl.sv - scoreboard bench for led_flash_ctrl
// Two DUTs (retrigger on/off) share stimulus; a tick-count reference model feeds per-cycle expectations.
module tb_led_flash_ctrl;

  localparam int TD = 4;
  localparam int P  = 3;
  localparam int B  = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] trigger, blink_en, abort;
  logic [3:0] led_a, busy_a, done_a;
  logic [3:0] led_b, busy_b, done_b;

  int errors = 0;
  int checks = 0;

  led_flash_ctrl #(.N_CH(4), .SYS_FREQ(4000), .PERIOD_MS(P), .BLINK_MS(B), .RETRIGGER(1'b1)) u_dut_rt1 (
    .clk(clk), .reset(reset), .trigger(trigger), .blink_en(blink_en), .abort(abort),
    .led_on(led_a), .busy(busy_a), .done(done_a)
  );

  led_flash_ctrl #(.N_CH(4), .SYS_FREQ(4000), .PERIOD_MS(P), .BLINK_MS(B), .RETRIGGER(1'b0)) u_dut_rt0 (
    .clk(clk), .reset(reset), .trigger(trigger), .blink_en(blink_en), .abort(abort),
    .led_on(led_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // reference model: activity flag and ticks seen since (re)entry per channel
  bit         act [2][4];
  int         ts  [2][4];
  bit         md  [2][4];
  logic [3:0] prev;
  int         m_cyc;
  logic [11:0] q_a[$];
  logic [11:0] q_b[$];

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        act[d][i] = 1'b0; ts[d][i] = 0; md[d][i] = 1'b0;
      end
    prev  = 4'b0;
    m_cyc = 0;
    q_a.delete();
    q_b.delete();
  endtask

  task automatic model_step();
    bit tk;
    logic [11:0] ev [2];
    tk = (m_cyc % TD) == TD - 1;
    m_cyc++;
    for (int d = 0; d < 2; d++) begin
      logic [3:0] l, bz, dn;
      l = 4'b0; bz = 4'b0; dn = 4'b0;
      for (int i = 0; i < 4; i++) begin
        bit r;
        r = trigger[i] && !prev[i];
        if (!act[d][i]) begin
          if (r && !abort[i]) begin
            act[d][i] = 1'b1; ts[d][i] = 0; md[d][i] = blink_en[i];
          end
        end else if (abort[i]) begin
          act[d][i] = 1'b0;
        end else if (r && d == 0) begin
          ts[d][i] = 0; md[d][i] = blink_en[i];
        end else if (tk) begin
          ts[d][i]++;
          if (ts[d][i] == P) begin
            act[d][i] = 1'b0; dn[i] = 1'b1;
          end
        end
        bz[i] = act[d][i];
        l[i]  = act[d][i] && (!md[d][i] || ((ts[d][i] / B) % 2 == 0));
      end
      ev[d] = {l, bz, dn};
    end
    q_a.push_back(ev[0]);
    q_b.push_back(ev[1]);
    prev = trigger;
  endtask

  logic [11:0] mon_ea, mon_eb;
  always @(posedge clk) begin
    #1;
    if (!reset && q_a.size() > 0) begin
      mon_ea = q_a.pop_front();
      mon_eb = q_b.pop_front();
      checks += 2;
      if ({led_a, busy_a, done_a} !== mon_ea) begin
        errors++;
        $display("FAIL sb_rt1 t=%0t {led,busy,done} got=%h required=%h", $time, {led_a, busy_a, done_a}, mon_ea);
      end
      if ({led_b, busy_b, done_b} !== mon_eb) begin
        errors++;
        $display("FAIL sb_rt0 t=%0t {led,busy,done} got=%h required=%h", $time, {led_b, busy_b, done_b}, mon_eb);
      end
    end
  end

  int on_a = 0, on_b = 0, dn_a = 0, dn_b = 0, dn3_a = 0;
  always @(negedge clk) begin
    on_a  += int'(led_a[0]);
    on_b  += int'(led_b[0]);
    dn_a  += int'(done_a[0]);
    dn_b  += int'(done_b[0]);
    dn3_a += int'(done_a[3]);
  end

  task automatic chk(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic cyc(input logic [3:0] t, input logic [3:0] b, input logic [3:0] a);
    @(negedge clk);
    trigger  = t;
    blink_en = b;
    abort    = a;
    model_step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    model_step();
  endtask

  int s_on_a, s_on_b, s_dn_a, s_dn_b, s_dn3;
  task automatic snap();
    s_on_a = on_a; s_on_b = on_b; s_dn_a = dn_a; s_dn_b = dn_b; s_dn3 = dn3_a;
  endtask

  initial begin
    logic [3:0] t, b, a;
    reset = 1'b1; trigger = 4'b0; blink_en = 4'b0; abort = 4'b0;
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if ({led_a, busy_a, done_a, led_b, busy_b, done_b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state got=%h required=0", {led_a, busy_a, done_a, led_b, busy_b, done_b});
    end
    release_reset();

    // single solid activation on ch0
    snap();
    cyc(4'b0001, 4'b0, 4'b0);
    repeat (19) cyc(4'b0001, 4'b0, 4'b0);
    chk("solid_on_rt1", on_a - s_on_a, 9, 12);
    chk("solid_on_rt0", on_b - s_on_b, 9, 12);
    chk("solid_done_rt1", dn_a - s_dn_a, 1, 1);
    chk("solid_done_rt0", dn_b - s_dn_b, 1, 1);
    repeat (4) cyc(4'b0, 4'b0, 4'b0);

    // blink on ch1
    cyc(4'b0010, 4'b0010, 4'b0);
    repeat (16) cyc(4'b0000, 4'b0010, 4'b0);

    // retrigger 6 cycles into activation
    snap();
    cyc(4'b0001, 4'b0, 4'b0);
    repeat (5) cyc(4'b0000, 4'b0, 4'b0);
    cyc(4'b0001, 4'b0, 4'b0);
    repeat (25) cyc(4'b0001, 4'b0, 4'b0);
    chk("retrig_on_rt1", on_a - s_on_a, 15, 18);
    chk("retrig_on_rt0", on_b - s_on_b, 9, 12);
    chk("retrig_done_rt1", dn_a - s_dn_a, 1, 1);
    chk("retrig_done_rt0", dn_b - s_dn_b, 1, 1);
    cyc(4'b0, 4'b0, 4'b0);

    // abort 5 cycles in, then abort with a rise while idle
    snap();
    cyc(4'b0001, 4'b0, 4'b0);
    repeat (4) cyc(4'b0000, 4'b0, 4'b0);
    cyc(4'b0000, 4'b0, 4'b0001);
    repeat (15) cyc(4'b0000, 4'b0, 4'b0);
    chk("abort_on_rt1", on_a - s_on_a, 5, 5);
    chk("abort_done_rt1", dn_a - s_dn_a, 0, 0);
    chk("abort_done_rt0", dn_b - s_dn_b, 0, 0);
    cyc(4'b0001, 4'b0, 4'b0001);
    repeat (6) cyc(4'b0001, 4'b0, 4'b0);
    cyc(4'b0, 4'b0, 4'b0);

    // ch0 and ch3 two cycles apart, ch0 aborted
    snap();
    cyc(4'b0001, 4'b0, 4'b0);
    cyc(4'b0001, 4'b0, 4'b0);
    cyc(4'b1001, 4'b0, 4'b0);
    cyc(4'b1001, 4'b0, 4'b0001);
    repeat (20) cyc(4'b1001, 4'b0, 4'b0);
    chk("indep_done_ch0", dn_a - s_dn_a, 0, 0);
    chk("indep_done_ch3", dn3_a - s_dn3, 1, 1);
    cyc(4'b0, 4'b0, 4'b0);

    // reset mid-activation with trigger held high across release
    cyc(4'b0100, 4'b0, 4'b0);
    repeat (4) cyc(4'b0100, 4'b0, 4'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({led_a, busy_a, done_a, led_b, busy_b, done_b} !== 24'h0) begin
      errors++;
      $display("FAIL async_reset got=%h required=0", {led_a, busy_a, done_a, led_b, busy_b, done_b});
    end
    model_clear();
    @(negedge clk);
    release_reset();
    repeat (20) cyc(4'b0100, 4'b0, 4'b0);
    cyc(4'b0, 4'b0, 4'b0);

    // randomized traffic
    t = 4'b0; b = 4'b0; a = 4'b0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) t[i] = ~t[i];
        b[i] = 1'($urandom_range(0, 1));
        a[i] = ($urandom_range(0, 19) == 0);
      end
      cyc(t, b, a);
    end
    repeat (20) cyc(4'b0, 4'b0, 4'b0);
    @(posedge clk);
    #2;
    chk("queue_drained", q_a.size() + q_b.size(), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
